// File: rtl/mdio_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mdio_slave_responder
// Description : Clause-22 MDIO target. Decodes MDC/MDIO frames addressed to
//               PHY_ADDR into register write pulses and read requests on a
//               local bus, and serialises read data back onto MDIO.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_slave_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32,
    parameter int         TIMEOUT  = 1024
) (
    input  logic        CLK_50M,
    input  logic        rst,
    input  logic        MDC,
    inout  wire         MDIO,
    output logic        reg_wr,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_rd_req,
    output logic [4:0]  reg_rd_addr,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_err
);

    localparam int         C_TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [5:0] C_PRE_MIN = 6'(PRE_LEN);
    localparam logic [5:0] C_PRE_SAT = 6'd63;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ST   = 3'd1,
        S_OP   = 3'd2,
        S_PHY  = 3'd3,
        S_REG  = 3'd4,
        S_TA   = 3'd5,
        S_DATA = 3'd6
    } state_t;

    // synchronisers
    logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
    logic mdio_meta_q, mdio_sync_q;

    // frame decode state
    state_t              state_q,    state_d;
    logic [5:0]          pre_cnt_q,  pre_cnt_d;
    logic [3:0]          bit_cnt_q,  bit_cnt_d;
    logic [14:0]         shift_q,    shift_d;
    logic                is_read_q,  is_read_d;
    logic                hit_q,      hit_d;
    logic [4:0]          regad_q,    regad_d;
    logic [15:0]         rd_shift_q, rd_shift_d;
    logic                oe_q,       oe_d;
    logic                out_q,      out_d;
    logic [C_TMO_W-1:0]  tmo_q,      tmo_d;

    // local-bus outputs
    logic                reg_wr_q,      reg_wr_d;
    logic [4:0]          reg_wr_addr_q, reg_wr_addr_d;
    logic [15:0]         reg_wr_data_q, reg_wr_data_d;
    logic                reg_rd_req_q,  reg_rd_req_d;
    logic [4:0]          reg_rd_addr_q, reg_rd_addr_d;
    logic                busy_q,        busy_d;
    logic                frame_err_q,   frame_err_d;

    logic        w_mdc_rise;
    logic        w_bit;
    logic [15:0] w_shift_in;

    assign w_mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign w_bit      = mdio_sync_q;
    assign w_shift_in = {shift_q, w_bit};

    // Read data leaves the chip only from the registered enable/value pair.
    assign MDIO = oe_q ? out_q : 1'bz;

    assign reg_wr      = reg_wr_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_rd_req  = reg_rd_req_q;
    assign reg_rd_addr = reg_rd_addr_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;

    // Next-state decode; all frame progress happens only on mdc_rise cycles.
    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        is_read_d     = is_read_q;
        hit_d         = hit_q;
        regad_d       = regad_q;
        rd_shift_d    = rd_shift_q;
        oe_d          = oe_q;
        out_d         = out_q;
        reg_wr_d      = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_req_d  = 1'b0;
        reg_rd_addr_d = reg_rd_addr_q;
        frame_err_d   = 1'b0;

        // Idle-gap counter only runs while a frame is open.
        if (state_q == S_IDLE || w_mdc_rise) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + C_TMO_W'(1);
        end

        if (state_q != S_IDLE && !w_mdc_rise && tmo_q == C_TMO_LAST) begin
            // MDC stalled mid-frame: abandon it and let go of the line.
            state_d     = S_IDLE;
            pre_cnt_d   = '0;
            bit_cnt_d   = '0;
            oe_d        = 1'b0;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end else if (w_mdc_rise) begin
            case (state_q)
                S_IDLE: begin
                    if (w_bit) begin
                        if (pre_cnt_q != C_PRE_SAT) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end
                    end else begin
                        // The zero that ends a long-enough preamble is ST bit 0.
                        if (pre_cnt_q >= C_PRE_MIN) begin
                            state_d   = S_ST;
                            bit_cnt_d = '0;
                        end
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    if (w_bit) begin
                        state_d   = S_OP;
                        bit_cnt_d = '0;
                    end else begin
                        state_d     = S_IDLE;
                        pre_cnt_d   = '0;
                        frame_err_d = 1'b1;
                    end
                end
                S_OP: begin
                    shift_d = w_shift_in[14:0];
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        bit_cnt_d = '0;
                        case ({shift_q[0], w_bit})
                            2'b10: begin
                                is_read_d = 1'b1;
                                state_d   = S_PHY;
                            end
                            2'b01: begin
                                is_read_d = 1'b0;
                                state_d   = S_PHY;
                            end
                            default: begin
                                state_d     = S_IDLE;
                                pre_cnt_d   = '0;
                                frame_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_PHY: begin
                    shift_d = w_shift_in[14:0];
                    if (bit_cnt_q == 4'd4) begin
                        hit_d     = (w_shift_in[4:0] == PHY_ADDR);
                        state_d   = S_REG;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_REG: begin
                    shift_d = w_shift_in[14:0];
                    if (bit_cnt_q == 4'd4) begin
                        regad_d   = w_shift_in[4:0];
                        state_d   = S_TA;
                        bit_cnt_d = '0;
                        if (is_read_q && hit_q) begin
                            reg_rd_req_d  = 1'b1;
                            reg_rd_addr_d = w_shift_in[4:0];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        // TA1 stays released; turn the line around for TA2.
                        bit_cnt_d = 4'd1;
                        if (is_read_q && hit_q) begin
                            oe_d       = 1'b1;
                            out_d      = 1'b0;
                            rd_shift_d = reg_rd_data;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                        if (is_read_q && hit_q) begin
                            out_d      = rd_shift_q[15];
                            rd_shift_d = {rd_shift_q[14:0], 1'b0};
                        end
                    end
                end
                S_DATA: begin
                    shift_d = w_shift_in[14:0];
                    if (is_read_q && hit_q) begin
                        if (bit_cnt_q == 4'd15) begin
                            oe_d = 1'b0;
                        end else begin
                            out_d      = rd_shift_q[15];
                            rd_shift_d = {rd_shift_q[14:0], 1'b0};
                        end
                    end
                    if (bit_cnt_q == 4'd15) begin
                        state_d   = S_IDLE;
                        pre_cnt_d = '0;
                        bit_cnt_d = '0;
                        if (!is_read_q && hit_q) begin
                            reg_wr_d      = 1'b1;
                            reg_wr_addr_d = regad_q;
                            reg_wr_data_d = w_shift_in;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    pre_cnt_d = '0;
                    oe_d      = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // Synchronisers plus all decode/output state registers.
    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            mdc_meta_q    <= 1'b0;
            mdc_sync_q    <= 1'b0;
            mdc_prev_q    <= 1'b0;
            mdio_meta_q   <= 1'b0;
            mdio_sync_q   <= 1'b0;
            state_q       <= S_IDLE;
            pre_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            is_read_q     <= 1'b0;
            hit_q         <= 1'b0;
            regad_q       <= '0;
            rd_shift_q    <= '0;
            oe_q          <= 1'b0;
            out_q         <= 1'b0;
            tmo_q         <= '0;
            reg_wr_q      <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            reg_rd_req_q  <= 1'b0;
            reg_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            mdc_meta_q    <= MDC;
            mdc_sync_q    <= mdc_meta_q;
            mdc_prev_q    <= mdc_sync_q;
            mdio_meta_q   <= MDIO;
            mdio_sync_q   <= mdio_meta_q;
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            is_read_q     <= is_read_d;
            hit_q         <= hit_d;
            regad_q       <= regad_d;
            rd_shift_q    <= rd_shift_d;
            oe_q          <= oe_d;
            out_q         <= out_d;
            tmo_q         <= tmo_d;
            reg_wr_q      <= reg_wr_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_req_q  <= reg_rd_req_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mdio_slave_responder
// Description : Self-checking bench for mdio_slave_responder. Acts as the MDIO
//               master, builds frames from fields and predicts bus events and
//               the line as seen by the master from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_slave_responder;

    localparam logic [4:0] PHY  = 5'd1;
    localparam int         PRE  = 32;
    localparam int         TMO  = 1024;
    localparam int         HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        m_oe;
    logic        m_out;
    logic [15:0] rd_data;
    wire         mdio;
    logic        reg_wr, reg_rd_req, busy, frame_err;
    logic [4:0]  reg_wr_addr, reg_rd_addr;
    logic [15:0] reg_wr_data;

    always #5 clk = ~clk;

    assign mdio = m_oe ? m_out : 1'bz;
    pullup (mdio);

    mdio_slave_responder #(.PHY_ADDR(PHY), .PRE_LEN(PRE), .TIMEOUT(TMO)) dut (
        .CLK_50M     (clk),
        .rst         (rst),
        .MDC         (mdc),
        .MDIO        (mdio),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_req  (reg_rd_req),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // event monitor, sampled on the falling edge
    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, excl_viol = 0;
    logic [4:0]  wr_addr_seen = '0, rd_addr_seen = '0;
    logic [15:0] wr_data_seen = '0;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            wr_addr_seen = reg_wr_addr;
            wr_data_seen = reg_wr_data;
        end
        if (reg_rd_req) begin
            rd_cnt++;
            rd_addr_seen = reg_rd_addr;
        end
        if (frame_err) err_cnt++;
        if ((reg_wr && reg_rd_req) || (frame_err && (reg_wr || reg_rd_req))) excl_viol++;
    end

    // frame being played: bit value, master-drives flag, line seen, busy after bit
    logic fb[$];
    logic fo[$];
    logic seen[$];
    logic busyq[$];
    int   corrupt_idx = -1;

    task automatic push_bits(input logic [31:0] v, input int n, input logic oe);
        for (int i = n - 1; i >= 0; i--) begin
            fb.push_back(v[i]);
            fo.push_back(oe);
        end
    endtask

    task automatic build_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] ra, input logic [15:0] d);
        fb.delete();
        fo.delete();
        for (int i = 0; i < pre; i++) push_bits(32'd1, 1, 1'b1);
        push_bits(32'b01, 2, 1'b1);
        push_bits({30'd0, op}, 2, 1'b1);
        push_bits({27'd0, phy}, 5, 1'b1);
        push_bits({27'd0, ra}, 5, 1'b1);
        if (op == 2'b10) begin
            push_bits(32'd0, 2, 1'b0);
            push_bits(32'd0, 16, 1'b0);
        end else begin
            push_bits(32'b10, 2, 1'b1);
            push_bits({16'd0, d}, 16, 1'b1);
        end
        push_bits(32'd0, 2, 1'b0);
    endtask

    task automatic mdc_bit(input logic b, input logic oe);
        m_oe  = oe;
        m_out = b;
        repeat (HALF) @(negedge clk);
        seen.push_back(mdio);
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic play(input int n);
        seen.delete();
        busyq.delete();
        for (int i = 0; i < n; i++) begin
            mdc_bit(fb[i], fo[i]);
            busyq.push_back(busy);
            if (i == corrupt_idx) rd_data = ~rd_data;
        end
        m_oe = 1'b0;
    endtask

    function automatic logic [19:0] seen_window(input int base);
        logic [19:0] g;
        for (int k = 0; k < 20; k++) g[19-k] = seen[base+k];
        return g;
    endfunction

    task automatic test_reset();
        rst = 1'b1; mdc = 1'b0; m_oe = 1'b0; m_out = 1'b1; rd_data = '0;
        repeat (5) @(negedge clk);
        checks++;
        if ({reg_wr, reg_rd_req, busy, frame_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got %b want 0000", {reg_wr, reg_rd_req, busy, frame_err});
        end
        checks++;
        if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== 26'd0) begin
            errors++; $display("FAIL reset_buses got %h want 0", {reg_wr_addr, reg_wr_data, reg_rd_addr});
        end
        checks++;
        if (mdio !== 1'b1) begin errors++; $display("FAIL reset_mdio got %b want released(1)", mdio); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_basic();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        build_frame(PRE, 2'b01, PHY, 5'd5, 16'hA5A5);
        play(fb.size());
        checks++;
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr_count got %0d want 1", wr_cnt - w0); end
        checks++;
        if ({wr_addr_seen, wr_data_seen} !== {5'd5, 16'hA5A5}) begin
            errors++; $display("FAIL wr_payload got %h/%h want 05/a5a5", wr_addr_seen, wr_data_seen);
        end
        checks++;
        if ((rd_cnt - r0) + (err_cnt - e0) !== 0) begin
            errors++; $display("FAIL wr_spurious got rd %0d err %0d want 0", rd_cnt - r0, err_cnt - e0);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b want 0", busy); end
    endtask

    task automatic test_read_basic();
        int r0 = rd_cnt, w0 = wr_cnt;
        logic [19:0] got;
        rd_data = 16'h1234;
        build_frame(PRE, 2'b10, PHY, 5'd3, 16'h0000);
        corrupt_idx = PRE + 14;
        play(fb.size());
        corrupt_idx = -1;
        got = seen_window(PRE + 14);
        checks++;
        if (rd_cnt - r0 !== 1 || rd_addr_seen !== 5'd3) begin
            errors++; $display("FAIL rd_req got %0d@%0d want 1@3", rd_cnt - r0, rd_addr_seen);
        end
        checks++;
        if (reg_rd_addr !== 5'd3) begin errors++; $display("FAIL rd_addr_hold got %0d want 3", reg_rd_addr); end
        checks++;
        if (got !== {2'b10, 16'h1234, 2'b11}) begin
            errors++; $display("FAIL rd_line got %b want %b", got, {2'b10, 16'h1234, 2'b11});
        end
        checks++;
        if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rd_no_wr got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_not_addressed();
        int r0 = rd_cnt, w0 = wr_cnt;
        logic [19:0] got;
        rd_data = 16'h0000;
        build_frame(PRE, 2'b10, 5'd2, 5'd3, 16'h0000);
        play(fb.size());
        got = seen_window(PRE + 14);
        checks++;
        if (got !== 20'hFFFFF) begin errors++; $display("FAIL na_line got %b want all released", got); end
        checks++;
        if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin
            errors++; $display("FAIL na_pulses got rd %0d wr %0d want 0", rd_cnt - r0, wr_cnt - w0);
        end
        checks++;
        if (busyq[PRE] !== 1'b1 || busyq[PRE+20] !== 1'b1 || busyq[PRE+30] !== 1'b1) begin
            errors++; $display("FAIL na_busy got %b%b%b want 111", busyq[PRE], busyq[PRE+20], busyq[PRE+30]);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL na_busy_end got %b want 0", busy); end
    endtask

    task automatic test_preamble_and_op();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        int hi = 0;
        build_frame(PRE - 1, 2'b01, PHY, 5'd7, 16'hFFFF);
        fb.push_front(1'b0);
        fo.push_front(1'b1);
        play(fb.size());
        foreach (busyq[i]) if (busyq[i] === 1'b1) hi++;
        checks++;
        if ((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0) !== 0 || hi !== 0) begin
            errors++; $display("FAIL short_pre got wr %0d err %0d busy %0d want 0", wr_cnt - w0, err_cnt - e0, hi);
        end
        // OP = 11 after a valid preamble
        fb.delete(); fo.delete();
        for (int i = 0; i < PRE; i++) push_bits(32'd1, 1, 1'b1);
        push_bits(32'b0111, 4, 1'b1);
        push_bits(32'd0, 3, 1'b0);
        play(fb.size());
        checks++;
        if (err_cnt - e0 !== 1 || (wr_cnt - w0) + (rd_cnt - r0) !== 0) begin
            errors++; $display("FAIL bad_op got err %0d want 1", err_cnt - e0);
        end
        // ST = 00 after a valid preamble
        fb.delete(); fo.delete();
        for (int i = 0; i < PRE; i++) push_bits(32'd1, 1, 1'b1);
        push_bits(32'b00, 2, 1'b1);
        push_bits(32'd0, 2, 1'b0);
        play(fb.size());
        checks++;
        if (err_cnt - e0 !== 2 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_st got err %0d busy %b want 2/0", err_cnt - e0, busy);
        end
    endtask

    task automatic test_timeout();
        int r0 = rd_cnt, e0 = err_cnt;
        int cyc = 0;
        logic b_mid = 1'b0;
        build_frame(PRE, 2'b10, PHY, 5'd9, 16'h0000);
        play(PRE + 14);
        while (err_cnt == e0 && cyc < TMO + 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == TMO / 2) b_mid = busy;
        end
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL tmo_err got %0d want 1 (waited %0d)", err_cnt - e0, cyc); end
        checks++;
        if (cyc < TMO - 20 || cyc > TMO + 5) begin
            errors++; $display("FAIL tmo_latency got %0d want about %0d", cyc, TMO);
        end
        checks++;
        if (b_mid !== 1'b1 || busy !== 1'b0 || mdio !== 1'b1) begin
            errors++; $display("FAIL tmo_state got busy_mid %b busy %b mdio %b want 1/0/1", b_mid, busy, mdio);
        end
        checks++;
        if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL tmo_rdreq got %0d want 1", rd_cnt - r0); end
    endtask

    task automatic test_rst_mid_read();
        int w0, r0;
        logic [15:0] d = 16'($urandom) & 16'hFF7F;
        logic [4:0]  ra = 5'($urandom);
        logic [15:0] wd = 16'($urandom);
        rd_data = d;
        build_frame(PRE, 2'b10, PHY, 5'd4, 16'h0000);
        play(PRE + 24);
        checks++;
        if (mdio !== 1'b0) begin errors++; $display("FAIL rst_d7_driven got %b want 0", mdio); end
        w0 = wr_cnt; r0 = rd_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mdio !== 1'b1) begin errors++; $display("FAIL rst_release got %b want released(1)", mdio); end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ((wr_cnt - w0) + (rd_cnt - r0) !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_abort got wr %0d rd %0d busy %b want 0", wr_cnt - w0, rd_cnt - r0, busy);
        end
        build_frame(PRE, 2'b01, PHY, ra, wd);
        play(fb.size());
        checks++;
        if (wr_cnt - w0 !== 1 || wr_addr_seen !== ra || wr_data_seen !== wd) begin
            errors++; $display("FAIL rst_then_wr got %0d %h/%h want 1 %h/%h", wr_cnt - w0, wr_addr_seen, wr_data_seen, ra, wd);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 10; n++) begin
            int          pre = int'($urandom_range(PRE + 8, PRE));
            logic        rd  = 1'($urandom_range(1, 0));
            logic        hit = ($urandom_range(3, 0) != 0);
            logic [4:0]  phy = hit ? PHY : 5'($urandom);
            logic [4:0]  ra  = 5'($urandom);
            logic [15:0] d   = 16'($urandom);
            int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
            logic [4:0]  wa0 = reg_wr_addr, ra0 = reg_rd_addr;
            logic [15:0] wd0 = reg_wr_data;
            logic [19:0] want, got;
            if (!hit && phy == PHY) phy = phy ^ 5'd1;
            rd_data = d;
            build_frame(pre, rd ? 2'b10 : 2'b01, phy, ra, d);
            play(fb.size());
            got = seen_window(pre + 14);
            if (rd) want = hit ? {2'b10, d, 2'b11} : 20'hFFFFF;
            else    want = {2'b10, d, 2'b11};
            checks++;
            if (wr_cnt - w0 !== ((!rd && hit) ? 1 : 0) || rd_cnt - r0 !== ((rd && hit) ? 1 : 0) || err_cnt != e0) begin
                errors++; $display("FAIL rnd%0d_counts got wr %0d rd %0d err %0d (rd=%b hit=%b)",
                                   n, wr_cnt - w0, rd_cnt - r0, err_cnt - e0, rd, hit);
            end
            checks++;
            if (got !== want) begin errors++; $display("FAIL rnd%0d_line got %b want %b", n, got, want); end
            checks++;
            if (!rd && hit) begin
                if (reg_wr_addr !== ra || reg_wr_data !== d) begin
                    errors++; $display("FAIL rnd%0d_wr got %h/%h want %h/%h", n, reg_wr_addr, reg_wr_data, ra, d);
                end
            end else if (rd && hit) begin
                if (reg_rd_addr !== ra) begin
                    errors++; $display("FAIL rnd%0d_rdaddr got %h want %h", n, reg_rd_addr, ra);
                end
            end else if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== {wa0, wd0, ra0}) begin
                errors++; $display("FAIL rnd%0d_untouched got %h want %h", n,
                                   {reg_wr_addr, reg_wr_data, reg_rd_addr}, {wa0, wd0, ra0});
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (excl_viol !== 0) begin errors++; $display("FAIL exclusive got %0d overlaps want 0", excl_viol); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_not_addressed();
        test_preamble_and_op();
        test_timeout();
        test_rst_mid_read();
        test_random_frames();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
